hazard_md_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It decides each cycle whether F/D hold and E takes a bubble, based on register-operand hazards against the E and M stages (Tuse/Tnew rule). It also owns the multiply/divide busy sequencer, which blocks HI/LO-dependent instructions in D while a mult/div is in flight. It drives the enables and clears of the PC, D_REG and E_REG, and keeps a saturating stall-cycle performance counter.

---
 rtl/mips_pipe_pkg.sv | 16 +
 rtl/hazard_md_ctrl_if.sv | 45 ++++
 rtl/md_busy_seq.sv | 54 +++++
 rtl/hazard_md_ctrl.sv | 81 ++++++++
 tb/tb_hazard_md_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core control blocks.
// Holds the Tuse/Tnew encoding, register index width and the default
// multiply/divide latencies used by the hazard and md sequencing logic.
package mips_pipe_pkg;

  localparam int REG_W        = 5;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef logic [1:0]       tuse_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  // Tuse value meaning "operand not read"; larger than any Tnew, so never stalls.
  localparam tuse_t TUSE_NONE = 2'd3;

endpackage

// File: rtl/hazard_md_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/md controller.
//   master : datapath side, drives the D/E/M stage hazard information and
//            receives the enables, clears and status.
//   slave  : controller side (hazard_md_ctrl).
interface hazard_md_ctrl_if
  import mips_pipe_pkg::*;
#(
  parameter int PERF_W = 32
);
  reg_idx_t          rs_d;
  reg_idx_t          rt_d;
  tuse_t             tuse_rs_d;
  tuse_t             tuse_rt_d;
  logic              md_use_d;
  reg_idx_t          a3_e;
  tuse_t             tnew_e;
  logic              regwrite_e;
  reg_idx_t          a3_m;
  tuse_t             tnew_m;
  logic              regwrite_m;
  logic              md_start_e;
  logic              md_is_div_e;
  logic              pc_en;
  logic              d_en;
  logic              e_clr;
  logic              stall;
  logic              md_busy;
  logic              md_done;
  logic              md_overlap_err;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
           a3_e, tnew_e, regwrite_e, a3_m, tnew_m, regwrite_m,
           md_start_e, md_is_div_e,
    input  pc_en, d_en, e_clr, stall, md_busy, md_done, md_overlap_err, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
           a3_e, tnew_e, regwrite_e, a3_m, tnew_m, regwrite_m,
           md_start_e, md_is_div_e,
    output pc_en, d_en, e_clr, stall, md_busy, md_done, md_overlap_err, stall_cnt
  );
endinterface

// File: rtl/md_busy_seq.sv
// Multiply/divide busy sequencer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   md_start_i          : mult/div starting in E this cycle
//   md_is_div_i         : 1 = div/divu, 0 = mult/multu
//   md_busy_o           : unit busy (counter non-zero)
//   md_done_o           : last busy cycle
//   md_overlap_err_o    : sticky, a start arrived while busy
module md_busy_seq
  import mips_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_i,
  input  logic md_is_div_i,
  output logic md_busy_o,
  output logic md_done_o,
  output logic md_overlap_err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign md_busy_o        = (cnt_q != '0);
  assign md_done_o        = (cnt_q == CNT_W'(1));
  assign md_overlap_err_o = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (md_start_i) begin
      // A start always reloads, even on top of a running operation.
      cnt_d = md_is_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      err_d = err_q | md_busy_o;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/hazard_md_ctrl.sv
// Pipeline sequencing controller: decides F/D hold and E bubble from
// register hazards (Tuse/Tnew against E and M) and the mult/div busy state,
// drives PC/D_REG enables and the E_REG clear, and counts stalled cycles.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_md_ctrl_if.slave (stage hazard info in, enables,
//                md status and stall counter out)
module hazard_md_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_md_ctrl_if.slave  bus
);

  logic              hz_rs, hz_rt, hz_md, stall;
  logic              md_busy, md_done, md_err;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // A producer blocks the reader only if its result appears later than the
  // reader needs it. $0 is never a real dependency.
  function automatic logic reg_hazard(
    input reg_idx_t src, input tuse_t tuse,
    input logic we_e, input reg_idx_t a3e, input tuse_t tne,
    input logic we_m, input reg_idx_t a3m, input tuse_t tnm
  );
    return (src != '0) &&
           ((we_e && (a3e == src) && (tne > tuse)) ||
            (we_m && (a3m == src) && (tnm > tuse)));
  endfunction

  md_busy_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk              (clk),
    .reset            (reset),
    .md_start_i       (bus.md_start_e),
    .md_is_div_i      (bus.md_is_div_e),
    .md_busy_o        (md_busy),
    .md_done_o        (md_done),
    .md_overlap_err_o (md_err)
  );

  always_comb begin
    hz_rs = reg_hazard(bus.rs_d, bus.tuse_rs_d, bus.regwrite_e, bus.a3_e, bus.tnew_e,
                       bus.regwrite_m, bus.a3_m, bus.tnew_m);
    hz_rt = reg_hazard(bus.rt_d, bus.tuse_rt_d, bus.regwrite_e, bus.a3_e, bus.tnew_e,
                       bus.regwrite_m, bus.a3_m, bus.tnew_m);
    // While reset is held the busy counter is being discarded, so only a
    // start in E can still block an HI/LO user in D.
    hz_md = bus.md_use_d & ((md_busy & ~reset) | bus.md_start_e);
    stall = hz_rs | hz_rt | hz_md;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall          = stall;
  assign bus.pc_en          = ~stall;
  assign bus.d_en           = ~stall;
  assign bus.e_clr          = stall;
  assign bus.md_busy        = md_busy;
  assign bus.md_done        = md_done;
  assign bus.md_overlap_err = md_err;
  assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
module tb_hazard_md_ctrl;
  import mips_pipe_pkg::*;

  localparam int PW   = 4;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_md_ctrl_if #(.PERF_W(PW)) bus ();

  hazard_md_ctrl #(
    .MULT_CYC (MULT),
    .DIV_CYC  (DIV),
    .CNT_W    (4),
    .PERF_W   (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycle c is the interval after the c-th rising edge. An md op started in
  // cycle s keeps the unit busy in cycles s+1 .. s+N.
  int cyc = 0;
  int md_s = -2;
  int md_e = -1;
  bit err_m = 1'b0;
  int stall_total = 0;
  bit armed = 1'b0;

  function automatic bit busy_at(input int c);
    return (c > md_s) && (c <= md_e);
  endfunction

  function automatic bit dep(input logic [4:0] src, input logic [1:0] tuse);
    bit hit_e, hit_m;
    hit_e = bus.regwrite_e && bus.a3_e == src && int'(bus.tnew_e) > int'(tuse);
    hit_m = bus.regwrite_m && bus.a3_m == src && int'(bus.tnew_m) > int'(tuse);
    return (src != 0) && (hit_e || hit_m);
  endfunction

  function automatic bit model_stall(input int c);
    bit mdh;
    mdh = bus.md_use_d && ((busy_at(c) && !reset) || bus.md_start_e);
    return dep(bus.rs_d, bus.tuse_rs_d) || dep(bus.rt_d, bus.tuse_rt_d) || mdh;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      md_s = -2; md_e = -1; err_m = 1'b0; stall_total = 0;
      armed = 1'b1;
    end else begin
      if (model_stall(cyc)) stall_total++;
      if (bus.md_start_e) begin
        if (busy_at(cyc)) err_m = 1'b1;
        md_s = cyc;
        md_e = cyc + (bus.md_is_div_e ? DIV : MULT);
      end
    end
    cyc++;
  end

  // Compare every cycle at the falling edge.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      bit st;
      int sc;
      st = model_stall(cyc);
      sc = (stall_total > (1 << PW) - 1) ? (1 << PW) - 1 : stall_total;
      chk("m_stall",   bus.stall, st);
      chk("m_pc_en",   bus.pc_en, !st);
      chk("m_d_en",    bus.d_en,  !st);
      chk("m_e_clr",   bus.e_clr, st);
      chk("m_busy",    bus.md_busy, busy_at(cyc));
      chk("m_done",    bus.md_done, busy_at(cyc) && cyc == md_e);
      chk("m_err",     bus.md_overlap_err, err_m);
      chk("m_stall_cnt", bus.stall_cnt, sc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear();
    bus.rs_d = '0; bus.rt_d = '0;
    bus.tuse_rs_d = TUSE_NONE; bus.tuse_rt_d = TUSE_NONE;
    bus.md_use_d = 1'b0;
    bus.a3_e = '0; bus.tnew_e = '0; bus.regwrite_e = 1'b0;
    bus.a3_m = '0; bus.tnew_m = '0; bus.regwrite_m = 1'b0;
    bus.md_start_e = 1'b0; bus.md_is_div_e = 1'b0;
  endtask

  initial begin
    clear();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    look();
    chk("rst_busy", bus.md_busy, 1'b0);
    chk("rst_err", bus.md_overlap_err, 1'b0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_stall", bus.stall, 1'b0);

    // Load-use on rs against E.
    step(); bus.regwrite_e = 1; bus.a3_e = 8; bus.tnew_e = 2; bus.rs_d = 8; bus.tuse_rs_d = 0;
    look();
    chk("lu_stall", bus.stall, 1'b1);
    chk("lu_pc_en", bus.pc_en, 1'b0);
    chk("lu_d_en", bus.d_en, 1'b0);
    chk("lu_e_clr", bus.e_clr, 1'b1);
    step(); bus.tnew_e = 0;
    look();
    chk("lu_tnew0", bus.stall, 1'b0);
    chk("lu_cnt1", bus.stall_cnt, 1);

    // $0 never stalls; M-stage rt hit does; Tuse none never does.
    step(); clear(); bus.regwrite_e = 1; bus.a3_e = 0; bus.tnew_e = 2; bus.rs_d = 0; bus.tuse_rs_d = 0;
    look();
    chk("zero_reg", bus.stall, 1'b0);
    step(); clear(); bus.regwrite_m = 1; bus.a3_m = 5; bus.tnew_m = 1; bus.rt_d = 5; bus.tuse_rt_d = 0;
    look();
    chk("m_hit", bus.stall, 1'b1);
    step(); bus.tuse_rt_d = TUSE_NONE;
    look();
    chk("tuse_none", bus.stall, 1'b0);
    chk("cnt2", bus.stall_cnt, 2);

    // mult then mflo.
    step(); clear(); bus.md_start_e = 1; bus.md_use_d = 1;
    look();
    chk("mul_k0_stall", bus.stall, 1'b1);
    chk("mul_k0_busy", bus.md_busy, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(); bus.md_start_e = 0;
      look();
      chk("mul_stall", bus.stall, k <= 5);
      chk("mul_busy", bus.md_busy, k <= 5);
      chk("mul_done", bus.md_done, k == 5);
    end
    chk("cnt8", bus.stall_cnt, 8);

    // div, then an illegal restart at t+3.
    step(); clear(); bus.md_start_e = 1; bus.md_is_div_e = 1;
    look();
    for (int k = 1; k <= 14; k++) begin
      step(); bus.md_start_e = (k == 3); bus.md_is_div_e = 1;
      look();
      chk("div_busy", bus.md_busy, k <= 13);
      chk("div_done", bus.md_done, k == 13);
      chk("div_err", bus.md_overlap_err, k >= 4);
    end

    // Restart exactly on the done cycle.
    step(); clear(); reset = 1;
    step(); reset = 0;
    look();
    chk("rst2_err", bus.md_overlap_err, 1'b0);
    step(); bus.md_start_e = 1;
    look();
    for (int k = 1; k <= 11; k++) begin
      step(); bus.md_start_e = (k == 5);
      look();
      chk("ovl_busy", bus.md_busy, k <= 10);
      chk("ovl_done", bus.md_done, k == 5 || k == 10);
      chk("ovl_err", bus.md_overlap_err, k >= 6);
    end

    // Reset in the middle of a div.
    step(); clear(); reset = 1;
    step(); reset = 0;
    step(); bus.md_start_e = 1; bus.md_is_div_e = 1;
    look();
    for (int k = 1; k <= 3; k++) begin
      step(); bus.md_start_e = 0;
    end
    step(); reset = 1; bus.md_use_d = 1;
    look();
    chk("rmid_busy_held", bus.md_busy, 1'b1);
    chk("rmid_stall_rst", bus.stall, 1'b0);
    step(); reset = 0;
    look();
    chk("rmid_busy", bus.md_busy, 1'b0);
    chk("rmid_done", bus.md_done, 1'b0);
    chk("rmid_cnt", bus.stall_cnt, 0);
    chk("rmid_mflo", bus.stall, 1'b0);
    step(); reset = 1; bus.md_start_e = 1;
    look();
    chk("rst_start_stall", bus.stall, 1'b1);
    step(); reset = 0; bus.md_start_e = 0; bus.md_use_d = 0;
    look();
    chk("rst_start_busy", bus.md_busy, 1'b0);

    // Saturating stall counter (4 bits).
    for (int k = 1; k <= 19; k++) begin
      step(); clear(); bus.regwrite_e = 1; bus.a3_e = 9; bus.tnew_e = 1; bus.rt_d = 9; bus.tuse_rt_d = 0;
      look();
      chk("sat_cnt", bus.stall_cnt, (k - 1 < 15) ? k - 1 : 15);
    end
    step(); clear();
    look();
    chk("sat_hold", bus.stall_cnt, 15);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
